// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction field positions and immediate modes.
package mips_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SA_LSB     = 6;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned INDEX_W    = 26;

    typedef enum logic [1:0] {
        SIGN  = 2'd0,
        ZERO  = 2'd1,
        UPPER = 2'd2
    } imm_mode_t;

    // Logical immediates zero-extend, LUI loads the upper half, everything else sign-extends.
    function automatic imm_mode_t imm_mode(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return ZERO;
            OP_LUI:                   return UPPER;
            default:                  return SIGN;
        endcase
    endfunction

    // Opcodes whose rt field is a source operand (and so can suffer a load-use hazard).
    function automatic logic reads_rt(input logic [5:0] op);
        case (op)
            OP_R_TYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_hz_register_bank.sv
// Register bank with write-through bypass.
// Ports: i_clock/i_reset, write port (i_write_en, i_write_sel, i_write_data),
//        read ports 0/1 and debug (sel in, comb data out). Register 0 is hardwired to zero.
module register_bank #(
    parameter int unsigned N_BITS     = 32,
    parameter int unsigned N_BITS_REG = 5,
    parameter int unsigned N_REGS     = 2**N_BITS_REG
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_write_en,
    input  logic [N_BITS_REG-1:0] i_write_sel,
    input  logic [N_BITS-1:0]     i_write_data,
    input  logic [N_BITS_REG-1:0] i_read_sel_0,
    input  logic [N_BITS_REG-1:0] i_read_sel_1,
    input  logic [N_BITS_REG-1:0] i_dbg_sel,
    output logic [N_BITS-1:0]     o_read_data_0,
    output logic [N_BITS-1:0]     o_read_data_1,
    output logic [N_BITS-1:0]     o_dbg_data
);

    logic [N_BITS-1:0] r_regs [N_REGS];
    logic              w_write_live;

    assign w_write_live = i_write_en && (i_write_sel != '0);

    // Same-cycle writeback data wins over the stored value.
    function automatic logic [N_BITS-1:0] read_port(input logic [N_BITS_REG-1:0] sel);
        if (sel == '0)
            return '0;
        else if (w_write_live && (i_write_sel == sel))
            return i_write_data;
        else
            return r_regs[sel];
    endfunction

    always_comb begin
        o_read_data_0 = read_port(i_read_sel_0);
        o_read_data_1 = read_port(i_read_sel_1);
        o_dbg_data    = read_port(i_dbg_sel);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < int'(N_REGS); i++)
                r_regs[i] <= '0;
        end else if (w_write_live) begin
            r_regs[i_write_sel] <= i_write_data;
        end
    end

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS decode stage: IF/ID register, register bank, immediate extension,
// load-use stall, flush, freeze and a registered ID/EX output slot.
// Inputs: clock/reset/enable, fetch (valid, instruction, pc_next), flush,
//         EX load info, writeback port, debug select.
// Outputs: o_stall and o_dbg_reg_data (comb), ID/EX fields/operands with o_valid.
module decode_stage_hz
    import mips_pkg::*;
#(
    parameter int unsigned N_BITS     = 32,
    parameter int unsigned N_BITS_REG = 5,
    parameter int unsigned N_REGS     = 2**N_BITS_REG
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic [N_BITS-1:0]     i_instruction,
    input  logic [N_BITS-1:0]     i_pc_next,
    input  logic                  i_flush,
    input  logic                  i_ex_mem_read,
    input  logic [N_BITS_REG-1:0] i_ex_rt,
    input  logic                  i_reg_write,
    input  logic [N_BITS_REG-1:0] i_data_reg_write_sel,
    input  logic [N_BITS-1:0]     i_data_reg_write,
    input  logic [N_BITS_REG-1:0] i_dbg_reg_sel,
    output logic [N_BITS-1:0]     o_dbg_reg_data,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [5:0]            o_opcode,
    output logic [5:0]            o_funct,
    output logic [N_BITS_REG-1:0] o_rs,
    output logic [N_BITS_REG-1:0] o_rt,
    output logic [N_BITS_REG-1:0] o_rd,
    output logic [N_BITS_REG-1:0] o_sa,
    output logic [N_BITS-1:0]     o_pc_next,
    output logic [N_BITS-1:0]     o_data_read_reg_0,
    output logic [N_BITS-1:0]     o_data_read_reg_1,
    output logic [N_BITS-1:0]     o_extended,
    output logic [INDEX_W-1:0]    o_instruction_index
);

    localparam int unsigned EXT_W = N_BITS - IMM_W;

    // IF/ID register
    logic              r_ifid_valid;
    logic [N_BITS-1:0] r_ifid_instr;
    logic [N_BITS-1:0] r_ifid_pc;

    // ID/EX register
    logic                  r_valid;
    logic [5:0]            r_opcode;
    logic [5:0]            r_funct;
    logic [N_BITS_REG-1:0] r_rs, r_rt, r_rd, r_sa;
    logic [N_BITS-1:0]     r_pc_next, r_data_0, r_data_1, r_extended;
    logic [INDEX_W-1:0]    r_index;

    // Decoded IF/ID fields
    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [N_BITS_REG-1:0] w_rs, w_rt, w_rd, w_sa;
    logic [IMM_W-1:0]      w_imm;
    logic [N_BITS-1:0]     w_extended;
    logic [N_BITS-1:0]     w_data_0, w_data_1;
    logic                  w_stall;

    assign w_opcode = r_ifid_instr[OPCODE_LSB +: 6];
    assign w_funct  = r_ifid_instr[5:0];
    assign w_rs     = r_ifid_instr[RS_LSB +: N_BITS_REG];
    assign w_rt     = r_ifid_instr[RT_LSB +: N_BITS_REG];
    assign w_rd     = r_ifid_instr[RD_LSB +: N_BITS_REG];
    assign w_sa     = r_ifid_instr[SA_LSB +: N_BITS_REG];
    assign w_imm    = r_ifid_instr[IMM_W-1:0];

    always_comb begin
        w_extended = {{EXT_W{w_imm[IMM_W-1]}}, w_imm};
        case (imm_mode(w_opcode))
            ZERO:    w_extended = {{EXT_W{1'b0}}, w_imm};
            UPPER:   w_extended = {w_imm, {EXT_W{1'b0}}};
            default: w_extended = {{EXT_W{w_imm[IMM_W-1]}}, w_imm};
        endcase
    end

    // Load-use hazard: rs is always a source, rt only for opcodes that read it.
    assign w_stall = r_ifid_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                     ((i_ex_rt == w_rs) || ((i_ex_rt == w_rt) && reads_rt(w_opcode)));
    assign o_stall = w_stall;

    register_bank #(
        .N_BITS     (N_BITS),
        .N_BITS_REG (N_BITS_REG),
        .N_REGS     (N_REGS)
    ) u_register_bank (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_write_en   (i_enable && i_reg_write),
        .i_write_sel  (i_data_reg_write_sel),
        .i_write_data (i_data_reg_write),
        .i_read_sel_0 (w_rs),
        .i_read_sel_1 (w_rt),
        .i_dbg_sel    (i_dbg_reg_sel),
        .o_read_data_0(w_data_0),
        .o_read_data_1(w_data_1),
        .o_dbg_data   (o_dbg_reg_data)
    );

    // Pipeline advance: reset > freeze > flush > stall > normal.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_funct      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_sa         <= '0;
            r_pc_next    <= '0;
            r_data_0     <= '0;
            r_data_1     <= '0;
            r_extended   <= '0;
            r_index      <= '0;
        end else if (i_enable) begin
            if (i_flush) begin
                r_ifid_valid <= 1'b0;
                r_valid      <= 1'b0;
            end else if (w_stall) begin
                r_valid      <= 1'b0;
            end else begin
                r_ifid_valid <= i_valid;
                r_ifid_instr <= i_instruction;
                r_ifid_pc    <= i_pc_next;
                r_valid      <= r_ifid_valid;
                r_opcode     <= w_opcode;
                r_funct      <= w_funct;
                r_rs         <= w_rs;
                r_rt         <= w_rt;
                r_rd         <= w_rd;
                r_sa         <= w_sa;
                r_pc_next    <= r_ifid_pc;
                r_data_0     <= w_data_0;
                r_data_1     <= w_data_1;
                r_extended   <= w_extended;
                r_index      <= r_ifid_instr[INDEX_W-1:0];
            end
        end
    end

    assign o_valid             = r_valid;
    assign o_opcode            = r_opcode;
    assign o_funct             = r_funct;
    assign o_rs                = r_rs;
    assign o_rt                = r_rt;
    assign o_rd                = r_rd;
    assign o_sa                = r_sa;
    assign o_pc_next           = r_pc_next;
    assign o_data_read_reg_0   = r_data_0;
    assign o_data_read_reg_1   = r_data_1;
    assign o_extended          = r_extended;
    assign o_instruction_index = r_index;

endmodule

// File: tb/tb_decode_stage_hz.sv
module tb_decode_stage_hz;

    localparam logic [31:0] I_ADDI  = 32'h2001FFFB; // ADDI $1,$0,-5
    localparam logic [31:0] I_ORI   = 32'h34028001; // ORI  $2,$0,0x8001
    localparam logic [31:0] I_LUI   = 32'h3C031234; // LUI  $3,0x1234
    localparam logic [31:0] I_ADD65 = 32'h00A53020; // ADD  $6,$5,$5
    localparam logic [31:0] I_ADD70 = 32'h00003820; // ADD  $7,$0,$0
    localparam logic [31:0] I_ADD74 = 32'h00813820; // ADD  $7,$4,$1

    logic        clk = 1'b0;
    logic        reset, enable, valid, flush, ex_mem_read, reg_write;
    logic [31:0] instruction, pc_next, wdata;
    logic [4:0]  ex_rt, wsel, dbg_sel;
    logic [31:0] dbg_data, pc_out, d0, d1, ext;
    logic        stall, ovalid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [25:0] index;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage_hz dut (
        .i_clock              (clk),
        .i_reset              (reset),
        .i_enable             (enable),
        .i_valid              (valid),
        .i_instruction        (instruction),
        .i_pc_next            (pc_next),
        .i_flush              (flush),
        .i_ex_mem_read        (ex_mem_read),
        .i_ex_rt              (ex_rt),
        .i_reg_write          (reg_write),
        .i_data_reg_write_sel (wsel),
        .i_data_reg_write     (wdata),
        .i_dbg_reg_sel        (dbg_sel),
        .o_dbg_reg_data       (dbg_data),
        .o_stall              (stall),
        .o_valid              (ovalid),
        .o_opcode             (opcode),
        .o_funct              (funct),
        .o_rs                 (rs),
        .o_rt                 (rt),
        .o_rd                 (rd),
        .o_sa                 (sa),
        .o_pc_next            (pc_out),
        .o_data_read_reg_0    (d0),
        .o_data_read_reg_1    (d1),
        .o_extended           (ext),
        .o_instruction_index  (index)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        valid = 1'b1; instruction = ins; pc_next = pc;
    endtask

    task automatic idle();
        valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; reg_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; idle(); instruction = '0; pc_next = '0;
        wsel = '0; wdata = '0; dbg_sel = '0;
        step(); step();
        reset = 1'b0;
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ovalid); end
        tests++; if (ext !== 32'h0 || pc_out !== 32'h0 || d0 !== 32'h0 || index !== 26'h0) begin
            fails++; $display("FAIL reset_data got ext=%h pc=%h d0=%h idx=%h exp all 0", ext, pc_out, d0, index); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
        dbg_sel = 5'd7;
        #1;
        tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL reset_bank got %h exp 0", dbg_data); end
    endtask

    task automatic test_immediates();
        fetch(I_ADDI, 32'h104); step();
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL latency_one_edge got %b exp 0", ovalid); end
        fetch(I_ORI, 32'h108); step();
        tests++; if (ovalid !== 1'b1 || rt !== 5'd1 || ext !== 32'hFFFFFFFB) begin
            fails++; $display("FAIL addi got v=%b rt=%0d ext=%h exp v=1 rt=1 ext=fffffffb", ovalid, rt, ext); end
        tests++; if (pc_out !== 32'h104 || opcode !== 6'h08 || index !== 26'h001FFFB) begin
            fails++; $display("FAIL addi_fields got pc=%h op=%h idx=%h exp 104 08 001fffb", pc_out, opcode, index); end
        fetch(I_LUI, 32'h10C); step();
        tests++; if (ovalid !== 1'b1 || ext !== 32'h00008001 || rt !== 5'd2) begin
            fails++; $display("FAIL ori got v=%b ext=%h rt=%0d exp v=1 ext=00008001 rt=2", ovalid, ext, rt); end
        valid = 1'b0; step();
        tests++; if (ovalid !== 1'b1 || ext !== 32'h12340000 || opcode !== 6'h0F) begin
            fails++; $display("FAIL lui got v=%b ext=%h op=%h exp v=1 ext=12340000 op=0f", ovalid, ext, opcode); end
        step();
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL drain got %b exp 0", ovalid); end
    endtask

    task automatic test_bypass();
        fetch(I_ADD65, 32'h200); step();
        valid = 1'b0; reg_write = 1'b1; wsel = 5'd5; wdata = 32'h0000CAFE; dbg_sel = 5'd5;
        #1;
        tests++; if (dbg_data !== 32'h0000CAFE) begin fails++; $display("FAIL dbg_bypass got %h exp 0000cafe", dbg_data); end
        step();
        reg_write = 1'b0;
        tests++; if (ovalid !== 1'b1 || d0 !== 32'h0000CAFE || d1 !== 32'h0000CAFE) begin
            fails++; $display("FAIL rf_bypass got v=%b d0=%h d1=%h exp v=1 cafe cafe", ovalid, d0, d1); end
        tests++; if (rd !== 5'd6 || funct !== 6'h20 || rs !== 5'd5) begin
            fails++; $display("FAIL add_fields got rd=%0d funct=%h rs=%0d exp 6 20 5", rd, funct, rs); end
        #1;
        tests++; if (dbg_data !== 32'h0000CAFE) begin fails++; $display("FAIL rf_stored got %h exp 0000cafe", dbg_data); end
        fetch(I_ADD70, 32'h204); reg_write = 1'b1; wsel = 5'd0; wdata = 32'hDEADBEEF; dbg_sel = 5'd0;
        step();
        valid = 1'b0;
        #1;
        tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL r0_dbg got %h exp 0", dbg_data); end
        step();
        reg_write = 1'b0;
        tests++; if (ovalid !== 1'b1 || d0 !== 32'h0 || d1 !== 32'h0 || rd !== 5'd7) begin
            fails++; $display("FAIL r0_read got v=%b d0=%h d1=%h rd=%0d exp v=1 0 0 7", ovalid, d0, d1, rd); end
        step();
    endtask

    task automatic test_stall();
        // seed $4 so the issued ADD carries a known operand
        reg_write = 1'b1; wsel = 5'd4; wdata = 32'h00000044; step(); reg_write = 1'b0;
        fetch(I_ADD74, 32'h300); step();
        valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd4;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_rs got %b exp 1", stall); end
        step();
        ex_mem_read = 1'b0; ex_rt = 5'd0;
        #1;
        tests++; if (ovalid !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL bubble got v=%b stall=%b exp 0 0", ovalid, stall); end
        step();
        tests++; if (ovalid !== 1'b1 || rs !== 5'd4 || rd !== 5'd7 || d0 !== 32'h44) begin
            fails++; $display("FAIL after_stall got v=%b rs=%0d rd=%0d d0=%h exp 1 4 7 44", ovalid, rs, rd, d0); end
        // rt hazard on an R-type
        fetch(I_ADD74, 32'h304); step();
        valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_rt got %b exp 1", stall); end
        ex_rt = 5'd0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_r0 got %b exp 0", stall); end
        step();
        tests++; if (ovalid !== 1'b1) begin fails++; $display("FAIL no_stall_issue got %b exp 1", ovalid); end
        // ADDI's rt is a destination: no hazard
        fetch(I_ADDI, 32'h308); ex_mem_read = 1'b0; step();
        valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL addi_rt_no_stall got %b exp 0", stall); end
        step(); idle(); step();
    endtask

    task automatic test_flush();
        fetch(I_ADD74, 32'h400); step();
        fetch(I_ADDI, 32'h404); ex_mem_read = 1'b1; ex_rt = 5'd4; flush = 1'b1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_pre_stall got %b exp 1", stall); end
        step();
        flush = 1'b0;
        #1;
        tests++; if (ovalid !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL flush got v=%b stall=%b exp 0 0", ovalid, stall); end
        ex_mem_read = 1'b0; ex_rt = 5'd0; fetch(I_ADDI, 32'h408); step();
        valid = 1'b0;
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL flush_slot2 got %b exp 0", ovalid); end
        step();
        tests++; if (ovalid !== 1'b1 || ext !== 32'hFFFFFFFB || pc_out !== 32'h408) begin
            fails++; $display("FAIL post_flush got v=%b ext=%h pc=%h exp 1 fffffffb 408", ovalid, ext, pc_out); end
        step();
    endtask

    task automatic test_freeze();
        fetch(I_ADDI, 32'h500); step();
        fetch(I_LUI, 32'h504); step();
        enable = 1'b0; fetch(I_ORI, 32'h508); reg_write = 1'b1; wsel = 5'd9; wdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (ovalid !== 1'b1 || ext !== 32'hFFFFFFFB || pc_out !== 32'h500) begin
                fails++; $display("FAIL freeze_%0d got v=%b ext=%h pc=%h exp 1 fffffffb 500", i, ovalid, ext, pc_out); end
        end
        reg_write = 1'b0; dbg_sel = 5'd9;
        #1;
        tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL freeze_nowrite got %h exp 0", dbg_data); end
        enable = 1'b1; step();
        valid = 1'b0;
        tests++; if (ovalid !== 1'b1 || ext !== 32'h12340000) begin
            fails++; $display("FAIL resume_lui got v=%b ext=%h exp 1 12340000", ovalid, ext); end
        step();
        tests++; if (ovalid !== 1'b1 || ext !== 32'h00008001 || pc_out !== 32'h508) begin
            fails++; $display("FAIL resume_ori got v=%b ext=%h pc=%h exp 1 00008001 508", ovalid, ext, pc_out); end
        step();
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL resume_drain got %b exp 0", ovalid); end
    endtask

    task automatic test_reset_mid_stall();
        fetch(I_ADD74, 32'h600); step();
        valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd4; reset = 1'b1; step();
        reset = 1'b0;
        tests++; if (stall !== 1'b0 || ovalid !== 1'b0 || ext !== 32'h0) begin
            fails++; $display("FAIL reset_stall got stall=%b v=%b ext=%h exp 0 0 0", stall, ovalid, ext); end
        idle(); dbg_sel = 5'd4;
        #1;
        tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL reset_clears_bank got %h exp 0", dbg_data); end
        fetch(I_LUI, 32'h604); step();
        valid = 1'b0;
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL reset_lat1 got %b exp 0", ovalid); end
        step();
        tests++; if (ovalid !== 1'b1 || ext !== 32'h12340000) begin
            fails++; $display("FAIL reset_lat2 got v=%b ext=%h exp 1 12340000", ovalid, ext); end
    endtask

    initial begin
        test_reset();
        test_immediates();
        test_bypass();
        test_stall();
        test_flush();
        test_freeze();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
